// File: rtl/mac_pkg.sv
// Shared MAC definitions: accumulate-stage width and the byte type used by the adder.
package mac_pkg;
    localparam int ADDER_W = 8;
    typedef logic [7:0] byte_t;
endpackage

// File: rtl/eightbit_adder_full_adder.sv
// One-bit full adder cell; the accumulate adder chains eight of these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p_s;

    assign p_s  = a ^ b;
    assign s    = p_s ^ cin;
    assign cout = (a & b) | (cin & p_s);
endmodule

// File: rtl/eightbit_adder.sv
// 8-bit ripple-carry adder for the MAC accumulate stage, with carry/signed-overflow
// flags and an optional output register selected by REG_OUT.
module eightbit_adder
    import mac_pkg::*;
#(
    parameter int WIDTH   = ADDER_W,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    logic [WIDTH:0]   c_s;
    logic [WIDTH-1:0] sum_s;
    logic             overflow_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c_s[i]),
            .s    (sum_s[i]),
            .cout (c_s[i+1])
        );
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign overflow_s = c_s[WIDTH-1] ^ c_s[WIDTH];

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_r;
        logic             carry_r;
        logic             overflow_r;

        // Output register; reset clears the captured result without a clock edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_r      <= {WIDTH{1'b0}};
                carry_r    <= 1'b0;
                overflow_r <= 1'b0;
            end else begin
                sum_r      <= sum_s;
                carry_r    <= c_s[WIDTH];
                overflow_r <= overflow_s;
            end
        end

        assign sum       = sum_r;
        assign carry_out = carry_r;
        assign overflow  = overflow_r;
    end else begin : g_comb
        // Clock and reset have no role when the outputs are combinational.
        logic unused_clk_rst_s;
        assign unused_clk_rst_s = clk ^ rst;

        assign sum       = sum_s;
        assign carry_out = c_s[WIDTH];
        assign overflow  = overflow_s;
    end
endmodule

// File: tb/tb_eightbit_adder.sv
// Self-checking bench: combinational and registered adder instances against an
// arithmetic reference model.
module tb_eightbit_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a   = 8'h00;
    logic [7:0] b   = 8'h00;
    logic       cin = 1'b0;

    logic [7:0] c_sum, r_sum;
    logic       c_carry, r_carry, c_ovf, r_ovf;

    int errors = 0;
    int checks = 0;
    int exh_errors = 0;

    always #5 clk = ~clk;

    eightbit_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
        .sum(c_sum), .carry_out(c_carry), .overflow(c_ovf)
    );

    eightbit_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_reg (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
        .sum(r_sum), .carry_out(r_carry), .overflow(r_ovf)
    );

    // Reference: packed {carry, overflow, sum} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
        int unsigned t;
        logic [7:0]  s;
        logic        ov;
        t  = int'(x) + int'(y) + int'(ci);
        s  = t[7:0];
        ov = (x[7] == y[7]) && (s[7] != x[7]);
        return {t[8], ov, s};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {c,v,sum}=%b_%b_%h expected %b_%b_%h a=%h b=%h cin=%b",
                   tag, obs[9], obs[8], obs[7:0], exp[9], exp[8], exp[7:0], a, b, cin);
        end
    endtask

    task automatic apply(input logic [7:0] x, input logic [7:0] y, input logic ci);
        a = x; b = y; cin = ci;
        #1;
    endtask

    initial begin
        logic [9:0] exp_v;
        logic [9:0] held;

        // Reset state of the registered instance, no clock edge yet.
        #1;
        chk("reset_state", {r_carry, r_ovf, r_sum}, 10'd0);

        // Exhaustive, cin=0, combinational instance.
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                apply(8'(i), 8'(j), 1'b0);
                exp_v = model(8'(i), 8'(j), 1'b0);
                checks++;
                assert ({c_carry, c_sum} === {exp_v[9], exp_v[7:0]}) else begin
                    errors++;
                    exh_errors++;
                    $error("FAIL exhaustive: observed c=%b sum=%h expected c=%b sum=%h a=%h b=%h",
                           c_carry, c_sum, exp_v[9], exp_v[7:0], a, b);
                end
            end
        end
        if (exh_errors == 0) $display("No errors found.");

        // Registered instance must stay cleared while rst is held across many edges.
        chk("reset_hold_long", {r_carry, r_ovf, r_sum}, 10'd0);

        // Directed boundary cases.
        apply(8'hFF, 8'h01, 1'b0); chk("wrap",        {c_carry, c_ovf, c_sum}, {1'b1, 1'b0, 8'h00});
        apply(8'h7F, 8'h01, 1'b0); chk("ovf_pos",     {c_carry, c_ovf, c_sum}, {1'b0, 1'b1, 8'h80});
        apply(8'h80, 8'h80, 1'b0); chk("ovf_neg",     {c_carry, c_ovf, c_sum}, {1'b1, 1'b1, 8'h00});
        apply(8'h0F, 8'h00, 1'b1); chk("cin_ripple",  {c_carry, c_ovf, c_sum}, {1'b0, 1'b0, 8'h10});
        apply(8'hFF, 8'hFF, 1'b1); chk("cin_max",     {c_carry, c_ovf, c_sum}, {1'b1, 1'b0, 8'hFF});
        apply(8'h00, 8'h00, 1'b1); chk("cin_only",    {c_carry, c_ovf, c_sum}, {1'b0, 1'b0, 8'h01});

        // Random combinational vectors with cin.
        for (int k = 0; k < 300; k++) begin
            apply(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
            chk("rand_comb", {c_carry, c_ovf, c_sum}, model(a, b, cin));
        end

        // Registered latency: release reset with inputs changing in the same cycle.
        @(negedge clk);
        rst = 1'b0;
        a = 8'd100; b = 8'd55; cin = 1'b0;
        #1;
        chk("lat_before_edge", {r_carry, r_ovf, r_sum}, 10'd0);
        @(posedge clk); #1;
        chk("lat_after_edge", {r_carry, r_ovf, r_sum}, {1'b0, 1'b1, 8'd155});
        apply(8'd1, 8'd2, 1'b0);
        chk("lat_hold", {r_carry, r_ovf, r_sum}, {1'b0, 1'b1, 8'd155});
        @(posedge clk); #1;
        chk("lat_next", {r_carry, r_ovf, r_sum}, {1'b0, 1'b0, 8'd3});

        // Random registered vectors: value holds until the edge, then follows the model.
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            held = {r_carry, r_ovf, r_sum};
            a = 8'($urandom_range(255)); b = 8'($urandom_range(255)); cin = 1'($urandom_range(1));
            exp_v = model(a, b, cin);
            #1;
            chk("rand_reg_hold", {r_carry, r_ovf, r_sum}, held);
            @(posedge clk); #1;
            chk("rand_reg_cap", {r_carry, r_ovf, r_sum}, exp_v);
        end

        // Mid-cycle asynchronous reset.
        @(negedge clk);
        a = 8'd100; b = 8'd55; cin = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_155", {r_carry, r_ovf, r_sum}, {1'b0, 1'b1, 8'd155});
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset", {r_carry, r_ovf, r_sum}, 10'd0);
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", {r_carry, r_ovf, r_sum}, 10'd0);
        @(negedge clk);
        rst = 1'b0;
        a = 8'd10; b = 8'd20; cin = 1'b0;
        #1;
        chk("post_release_before_edge", {r_carry, r_ovf, r_sum}, 10'd0);
        @(posedge clk); #1;
        chk("post_release_capture", {r_carry, r_ovf, r_sum}, {1'b0, 1'b0, 8'd30});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
